bnn_seq_ctrl: RTL and testbench

//  Sequencer between the pad-level stream interface and the BNN compute core.
//  - Accepts 16-bit beats and routes them into the weight or activation buffer according to mode_port.
//  - Launches the processing-element (PE) array and waits for it to finish.
//  - Serializes the 2-bit class results onto data_out_port, qualified by out_en_port.

---
 rtl/bnn_ctrl_pkg.sv | 16 +
 rtl/bnn_out_serializer.sv | 65 ++++++
 rtl/bnn_seq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_bnn_seq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_ctrl_pkg.sv
// Shared types and constants for the BNN sequencer: FSM state encoding, mode values, watchdog result code.
package bnn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    localparam logic       MODE_WEIGHT   = 1'b1;
    localparam logic       MODE_INFER    = 1'b0;
    localparam logic [1:0] WDOG_ERR_CODE = 2'b11;

endpackage

// File: rtl/bnn_out_serializer.sv
// Result serializer: captures 2*NOUT bits on load_i and emits them 2 bits per cycle, LSB pair first.
module bnn_out_serializer #(
    parameter int unsigned NOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [2*NOUT-1:0] data_i,
    output logic [1:0]        data_o,
    output logic              valid_o,
    output logic              last_o
);

    localparam int unsigned BW = 2 * NOUT;
    localparam int unsigned CW = (NOUT > 1) ? $clog2(NOUT) : 1;

    logic [BW-1:0] sh_q, sh_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    // rem_q counts pairs still to come after the one currently on data_o
    always_comb begin
        sh_d    = sh_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load_i) begin
            sh_d    = data_i;
            rem_d   = CW'(NOUT - 1);
            valid_d = 1'b1;
            last_d  = (NOUT == 1);
        end else if (valid_q) begin
            if (last_q) begin
                sh_d    = '0;
                rem_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                sh_d   = sh_q >> 2;
                rem_d  = rem_q - CW'(1);
                last_d = (rem_q == CW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q    <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_o  = sh_q[1:0];
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Stream-to-BNN-core sequencer: buffers weight/activation beats, launches the PE array, serializes results.
// Optional RUN watchdog enabled by defining BNN_WDOG_EN.
module bnn_seq_ctrl
    import bnn_ctrl_pkg::*;
#(
    parameter int unsigned W_WORDS     = 64,
    parameter int unsigned X_WORDS     = 4,
    parameter int unsigned NOUT        = 4,
    parameter int unsigned AW          = 6,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_port,
    input  logic [15:0]       data_in_port,
    input  logic              in_valid_port,
    output logic              in_ready_port,
    output logic [1:0]        data_out_port,
    output logic              out_en_port,
    output logic              buf_wr_en,
    output logic              buf_sel,
    output logic [AW-1:0]     buf_wr_addr,
    output logic [15:0]       buf_wr_data,
    output logic              pe_start,
    input  logic              pe_done,
    input  logic [2*NOUT-1:0] pe_result,
    output logic              err_flag
);

    localparam int unsigned RW = 2 * NOUT;

    if (W_WORDS < 1 || X_WORDS < 1 || NOUT < 1 || WDOG_CYCLES < 1 ||
        (64'(1) << AW) < 64'(W_WORDS) || (64'(1) << AW) < 64'(X_WORDS)) begin : g_bad_params
        $error("bnn_seq_ctrl: illegal parameter combination");
    end

    state_t        state_q, state_d;
    logic          w_loaded_q, w_loaded_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic          sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          pe_start_q, pe_start_d;
    logic          accept_c;
    logic          ser_load_c;
    logic [RW-1:0] ser_data_c;
    logic          ser_last;
    logic          ser_valid;
    logic          wdog_exp_c;

    // Ready depends only on state, w_loaded and mode so valid never loops back into it
    always_comb begin
        in_ready_port = 1'b0;
        case (state_q)
            ST_IDLE:              in_ready_port = (mode_port == MODE_WEIGHT) | w_loaded_q;
            ST_LOAD_W, ST_LOAD_X: in_ready_port = 1'b1;
            default:              in_ready_port = 1'b0;
        endcase
    end

    assign accept_c = in_valid_port & in_ready_port;

    always_comb begin
        state_d    = state_q;
        w_loaded_d = w_loaded_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        sel_d      = sel_q;
        addr_d     = addr_q;
        data_d     = data_q;
        pe_start_d = 1'b0;
        ser_load_c = 1'b0;
        ser_data_c = pe_result;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    wr_en_d = 1'b1;
                    sel_d   = mode_port;
                    addr_d  = '0;
                    data_d  = data_in_port;
                    cnt_d   = AW'(1);
                    if (mode_port == MODE_WEIGHT) begin
                        if (W_WORDS == 1) begin
                            w_loaded_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            state_d = ST_LOAD_W;
                        end
                    end else if (X_WORDS == 1) begin
                        state_d    = ST_RUN;
                        pe_start_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        state_d = ST_LOAD_X;
                    end
                end
            end
            ST_LOAD_W: begin
                if (accept_c) begin
                    wr_en_d = 1'b1;
                    sel_d   = MODE_WEIGHT;
                    addr_d  = cnt_q;
                    data_d  = data_in_port;
                    cnt_d   = cnt_q + AW'(1);
                    if (cnt_q == AW'(W_WORDS - 1)) begin
                        cnt_d      = '0;
                        w_loaded_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_LOAD_X: begin
                if (accept_c) begin
                    wr_en_d = 1'b1;
                    sel_d   = MODE_INFER;
                    addr_d  = cnt_q;
                    data_d  = data_in_port;
                    cnt_d   = cnt_q + AW'(1);
                    if (cnt_q == AW'(X_WORDS - 1)) begin
                        cnt_d      = '0;
                        state_d    = ST_RUN;
                        pe_start_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // A real completion in the expiry cycle takes priority over the watchdog
                if (pe_done) begin
                    ser_load_c = 1'b1;
                    state_d    = ST_DRAIN;
                end else if (wdog_exp_c) begin
                    ser_load_c = 1'b1;
                    ser_data_c = {NOUT{WDOG_ERR_CODE}};
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ser_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            w_loaded_q <= 1'b0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            pe_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_loaded_q <= w_loaded_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            pe_start_q <= pe_start_d;
        end
    end

`ifdef BNN_WDOG_EN
    localparam int unsigned WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;

    assign wdog_exp_c = (state_q == ST_RUN) && (wdog_q == WDW'(WDOG_CYCLES - 1));

    // Counter is zero on RUN entry because it is held clear outside RUN
    always_comb begin
        wdog_d = '0;
        err_d  = err_q;
        if (state_q == ST_RUN && !wdog_exp_c) wdog_d = wdog_q + WDW'(1);
        if (wdog_exp_c && !pe_done)           err_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_flag = err_q;
`else
    assign wdog_exp_c = 1'b0;
    assign err_flag   = 1'b0;
`endif

    bnn_out_serializer #(
        .NOUT (NOUT)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ser_load_c),
        .data_i  (ser_data_c),
        .data_o  (data_out_port),
        .valid_o (ser_valid),
        .last_o  (ser_last)
    );

    assign out_en_port = ser_valid;
    assign buf_wr_en   = wr_en_q;
    assign buf_sel     = sel_q;
    assign buf_wr_addr = addr_q;
    assign buf_wr_data = data_q;
    assign pe_start    = pe_start_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Randomized self-checking bench for bnn_seq_ctrl; expectations come from a transaction-level model.
module tb_bnn_seq_ctrl;

    localparam int unsigned W_WORDS = 64;
    localparam int unsigned X_WORDS = 4;
    localparam int unsigned NOUT    = 4;
    localparam int unsigned AW      = 6;
    localparam int unsigned WDOG    = 16;
    localparam int unsigned RW      = 2 * NOUT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode_port = 1'b0;
    logic [15:0]   data_in_port = '0;
    logic          in_valid_port = 1'b0;
    logic          in_ready_port;
    logic [1:0]    data_out_port;
    logic          out_en_port;
    logic          buf_wr_en;
    logic          buf_sel;
    logic [AW-1:0] buf_wr_addr;
    logic [15:0]   buf_wr_data;
    logic          pe_start;
    logic          pe_done = 1'b0;
    logic [RW-1:0] pe_result = '0;
    logic          err_flag;

    bnn_seq_ctrl #(
        .W_WORDS     (W_WORDS),
        .X_WORDS     (X_WORDS),
        .NOUT        (NOUT),
        .AW          (AW),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_port     (mode_port),
        .data_in_port  (data_in_port),
        .in_valid_port (in_valid_port),
        .in_ready_port (in_ready_port),
        .data_out_port (data_out_port),
        .out_en_port   (out_en_port),
        .buf_wr_en     (buf_wr_en),
        .buf_sel       (buf_sel),
        .buf_wr_addr   (buf_wr_addr),
        .buf_wr_data   (buf_wr_data),
        .pe_start      (pe_start),
        .pe_done       (pe_done),
        .pe_result     (pe_result),
        .err_flag      (err_flag)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned start_cnt = 0;
    bit          err_exp = 1'b0;
    logic [63:0] wr_q[$];
    logic [63:0] exp_wr[$];

    function automatic logic [63:0] pack_wr(input logic sel, input logic [AW-1:0] a,
                                            input logic [15:0] d, input int unsigned c);
        return {9'd0, sel, a, d, c};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Observed buffer writes (with cycle stamp) and pe_start pulses
    always @(negedge clk) begin
        if (buf_wr_en) wr_q.push_back(pack_wr(buf_sel, buf_wr_addr, buf_wr_data, cyc));
        if (pe_start)  start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        while (exp_wr.size() > 0 && wr_q.size() > 0) check(tag, wr_q.pop_front(), exp_wr.pop_front());
        wr_q.delete();
        exp_wr.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},  64'(buf_wr_en),     64'(0));
        check({tag, "_sel"},    64'(buf_sel),       64'(0));
        check({tag, "_addr"},   64'(buf_wr_addr),   64'(0));
        check({tag, "_data"},   64'(buf_wr_data),   64'(0));
        check({tag, "_start"},  64'(pe_start),      64'(0));
        check({tag, "_out_en"}, 64'(out_en_port),   64'(0));
        check({tag, "_dout"},   64'(data_out_port), 64'(0));
        check({tag, "_err"},    64'(err_flag),      64'(0));
    endtask

    // Offer n beats; the model expects beat i written at address i one cycle after acceptance
    task automatic load_beats(input logic mode, input int unsigned n, input int unsigned max_gap,
                              input bit incr, output int unsigned last_acc);
        logic [15:0] d;
        bit          ok;
        int unsigned gap;
        last_acc = 0;
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < n; i++) begin
            d             = incr ? 16'(i) : 16'($urandom);
            mode_port     = (i == 0) ? mode : 1'($urandom);
            data_in_port  = d;
            in_valid_port = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 50 && !ok; w++) begin
                @(negedge clk);
                ok = in_ready_port;
            end
            check("beat_ready", 64'(ok), 64'(1));
            if (!ok) begin
                in_valid_port = 1'b0;
                return;
            end
            last_acc = cyc;
            exp_wr.push_back(pack_wr(mode, AW'(i), d, cyc + 1));
            @(posedge clk);
            #1;
            if (max_gap > 0 && i + 1 < n) begin
                gap = $urandom_range(max_gap, 0);
                if (gap > 0) begin
                    in_valid_port = 1'b0;
                    data_in_port  = 16'($urandom);
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
        end
        in_valid_port = 1'b0;
    endtask

    // One inference: activations, PE completes d cycles after pe_start (or never if no_done)
    task automatic run_infer(input int unsigned d, input logic [RW-1:0] res, input bit no_done);
        int unsigned   last_acc, s, st0;
        bit            got;
        logic [RW-1:0] exp_res;
        exp_res = no_done ? {RW{1'b1}} : res;
        wr_q.delete();
        exp_wr.delete();
        st0 = start_cnt;
        load_beats(1'b0, X_WORDS, 3, 1'b0, last_acc);
        mode_port = 1'($urandom);
        got = 1'b0;
        s   = 0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = pe_start;
            s   = cyc;
        end
        check("pe_start_seen", 64'(got), 64'(1));
        check("pe_start_cycle", 64'(s), 64'(last_acc + 1));
        for (int unsigned k = 0; k <= d; k++) begin
            if (k > 0) @(negedge clk);
            check("ready_run", 64'(in_ready_port), 64'(0));
            check("out_en_run", 64'(out_en_port), 64'(0));
            if (k == d && !no_done) begin
                pe_done   = 1'b1;
                pe_result = res;
            end
        end
        @(posedge clk);
        #1;
        pe_done   = 1'b0;
        pe_result = RW'($urandom);
        for (int unsigned k = 0; k < NOUT; k++) begin
            @(negedge clk);
            check("drain_en", 64'(out_en_port), 64'(1));
            check("drain_data", 64'(data_out_port), 64'(exp_res[2*k +: 2]));
            check("ready_drain", 64'(in_ready_port), 64'(0));
        end
        err_exp = err_exp | no_done;
        @(negedge clk);
        check("drain_end_en", 64'(out_en_port), 64'(0));
        check("idle_ready", 64'(in_ready_port), 64'(1));
        check("err_flag", 64'(err_flag), 64'(err_exp));
        #1;
        cmp_writes("x_write");
        check("pe_start_count", 64'(start_cnt - st0), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned la, st0;
        bit          got;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Inference before any weight load must stall
        mode_port     = 1'b0;
        data_in_port  = 16'($urandom);
        in_valid_port = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_ready", 64'(in_ready_port), 64'(0));
        end
        #1;
        in_valid_port = 1'b0;
        check("stall_writes", 64'(wr_q.size()), 64'(0));
        check("stall_start", 64'(start_cnt), 64'(0));

        // Back-to-back weight load, data = address
        wr_q.delete();
        load_beats(1'b1, W_WORDS, 0, 1'b1, la);
        @(negedge clk);
        #1;
        cmp_writes("w_write");
        mode_port = 1'b0;
        #1;
        check("w_loaded_ready", 64'(in_ready_port), 64'(1));

        // Directed inference, then pe_done coincident with pe_start
        run_infer(5, RW'(8'hE4), 1'b0);
        run_infer(0, RW'($urandom), 1'b0);

        // Stray pe_done in IDLE is ignored
        st0 = start_cnt;
        @(posedge clk);
        #1;
        pe_done   = 1'b1;
        pe_result = RW'($urandom);
        @(posedge clk);
        #1;
        pe_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stray_out_en", 64'(out_en_port), 64'(0));
        end
        check("stray_start", 64'(start_cnt - st0), 64'(0));

        // Randomized inferences
        for (int r = 0; r < 6; r++) run_infer($urandom_range(10, 0), RW'($urandom), 1'b0);

        // Reset in the middle of a weight load
        load_beats(1'b1, 30, 0, 1'b1, la);
        mode_port     = 1'b1;
        data_in_port  = 16'd30;
        in_valid_port = 1'b1;
        rst_n         = 1'b0;
        @(negedge clk);
        check("abort_prev_wr_en", 64'(buf_wr_en), 64'(1));
        check("abort_prev_addr", 64'(buf_wr_addr), 64'(29));
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        mode_port     = 1'b0;
        in_valid_port = 1'b1;
        wr_q.delete();
        exp_wr.delete();
        st0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_abort_ready", 64'(in_ready_port), 64'(0));
        end
        #1;
        in_valid_port = 1'b0;
        check("post_abort_writes", 64'(wr_q.size()), 64'(0));
        check("post_abort_start", 64'(start_cnt - st0), 64'(0));

        // Reload weights with random data and gaps
        load_beats(1'b1, W_WORDS, 2, 1'b0, la);
        @(negedge clk);
        #1;
        cmp_writes("w_reload");

`ifdef BNN_WDOG_EN
        run_infer(WDOG - 1, RW'($urandom), 1'b0);
        run_infer(WDOG - 1, RW'($urandom), 1'b1);
        run_infer(3, RW'($urandom), 1'b0);
`else
        st0 = start_cnt;
        load_beats(1'b0, X_WORDS, 1, 1'b0, la);
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = pe_start;
        end
        check("hang_start_seen", 64'(got), 64'(1));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("hang_out_en", 64'(out_en_port), 64'(0));
        end
        check("hang_ready", 64'(in_ready_port), 64'(0));
        check("hang_err", 64'(err_flag), 64'(0));
        check("hang_start_count", 64'(start_cnt - st0), 64'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
